// File: rtl/result_readback.sv
// result_readback: walks RAM2 addresses 0..NUM_WORDS-1 once per start and
//   streams the words out on valid/ready, keeping a 32-bit running checksum.
// Latency: start sampled at edge 0, first RAM2_OE at edge 1, first out_valid
//   at edge 2; one word per cycle after that while out_ready stays high.
// Backpressure: a 2-entry skid FIFO holds the head word plus one more. Reads
//   are only issued when they are sure to fit, so in-flight data is never lost.
// Ports: clk/rst (sync, active high); start; RAM2_OE/RAM2_A/RAM2_Q read port
//   (RAM2_Q is sampled on the edge that ends the RAM2_OE cycle);
//   out_data/out_valid/out_ready/out_last stream; checksum; busy; finished.
module result_readback #(
  parameter int DATA_W    = 24,
  parameter int ADDR_W    = 20,
  parameter int NUM_WORDS = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              RAM2_OE,
  output logic [ADDR_W-1:0] RAM2_A,
  input  logic [DATA_W-1:0] RAM2_Q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [31:0]       checksum,
  output logic              busy,
  output logic              finished
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   rd_addr;
  logic                inflight;       // a read was issued last edge; RAM2_Q is its data
  logic                inflight_last;  // that read targets LAST_ADDR
  logic [DATA_W-1:0]   tail_data;      // second FIFO entry; the head lives in out_*
  logic                tail_last;
  logic                tail_valid;
  logic                last_acc;       // final word has been taken downstream
  logic                pop;
  logic                push;
  logic                issue;
  logic                begin_pass;
  logic [1:0]          occ;

  assign pop  = out_valid & out_ready;
  assign push = inflight;

  // Entries that will be occupied after this cycle's pop, counting the word
  // still on its way from RAM2. A new read is safe only if this is below 2.
  // pop implies out_valid, so the subtraction cannot underflow.
  assign occ = {1'b0, out_valid} + {1'b0, tail_valid} + {1'b0, inflight} - {1'b0, pop};

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    begin_pass = 1'b0;
    busy       = 1'b0;
    finished   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          begin_pass = 1'b1;
          state_nxt  = READ;
        end
      end
      READ: begin
        busy  = 1'b1;
        issue = (occ < 2'd2);
        if (issue && (rd_addr == LAST_ADDR)) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!inflight && !out_valid && !tail_valid && last_acc) state_nxt = DONE;
      end
      DONE: begin
        finished = 1'b1;
        if (start) begin
          begin_pass = 1'b1;
          state_nxt  = READ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rd_addr       <= '0;
      RAM2_OE       <= 1'b0;
      RAM2_A        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      tail_data     <= '0;
      tail_last     <= 1'b0;
      tail_valid    <= 1'b0;
      checksum      <= '0;
      last_acc      <= 1'b0;
    end else begin
      state    <= state_nxt;
      RAM2_OE  <= issue;
      inflight <= issue;

      if (issue) begin
        RAM2_A        <= rd_addr;
        rd_addr       <= rd_addr + ADDR_W'(1);
        inflight_last <= (rd_addr == LAST_ADDR);
      end

      // begin_pass only occurs with an empty FIFO, so it never races a pop.
      if (begin_pass) begin
        rd_addr  <= '0;
        checksum <= '0;
        last_acc <= 1'b0;
      end else if (pop) begin
        checksum <= checksum + 32'(out_data);
        if (out_last) last_acc <= 1'b1;
      end

      // Skid FIFO: head in out_*, second entry in tail_*.
      if (pop) begin
        if (tail_valid) begin
          out_data   <= tail_data;
          out_last   <= tail_last;
          out_valid  <= 1'b1;
          tail_valid <= push;
          tail_last  <= push && inflight_last;
          if (push) tail_data <= RAM2_Q;
        end else begin
          out_valid <= push;
          out_last  <= push && inflight_last;
          if (push) out_data <= RAM2_Q;
        end
      end else if (push) begin
        if (!out_valid) begin
          out_data  <= RAM2_Q;
          out_last  <= inflight_last;
          out_valid <= 1'b1;
        end else begin
          tail_data  <= RAM2_Q;
          tail_last  <= inflight_last;
          tail_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_result_readback.sv
module tb_result_readback;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, out_ready, start1, ready1;
  logic        oe, oe1, v, v1, l, l1, busy, busy1, fin, fin1;
  logic [19:0] a, a1;
  logic [23:0] q, q1, d, d1;
  logic [31:0] cs, cs1;

  logic [23:0] mem [4096];
  logic [23:0] m1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [23:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_sum;

  // RAM2 models: data is presented while OE is high and taken on the closing
  // edge; a junk pattern otherwise so a mistimed capture is visible.
  assign q  = oe  ? mem[a[11:0]] : 24'h5A5A5A;
  assign q1 = oe1 ? m1           : 24'h5A5A5A;

  result_readback #(.DATA_W(24), .ADDR_W(20), .NUM_WORDS(4096)) dut (
    .clk(clk), .rst(rst), .start(start),
    .RAM2_OE(oe), .RAM2_A(a), .RAM2_Q(q),
    .out_data(d), .out_valid(v), .out_ready(out_ready), .out_last(l),
    .checksum(cs), .busy(busy), .finished(fin)
  );

  result_readback #(.DATA_W(24), .ADDR_W(20), .NUM_WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .RAM2_OE(oe1), .RAM2_A(a1), .RAM2_Q(q1),
    .out_data(d1), .out_valid(v1), .out_ready(ready1), .out_last(l1),
    .checksum(cs1), .busy(busy1), .finished(fin1)
  );

  // Fill RAM2, queue the expected stream and reference checksum, raise start.
  task automatic load_pass(input int kind);
    exp_t e;
    exp_q.delete();
    exp_sum = 32'd0;
    for (int i = 0; i < 4096; i++) begin
      case (kind)
        0:       mem[i] = 24'(i);
        1:       mem[i] = 24'($urandom);
        default: mem[i] = 24'hFFFFFF;
      endcase
      e.data = mem[i];
      e.last = (i == 4095);
      exp_q.push_back(e);
      exp_sum = exp_sum + 32'(mem[i]);
    end
    @(negedge clk);
    start = 1'b1;
  endtask

  // mode 0: ready=1; 1: random ready; 2: ready low 10 cycles after word 100;
  // 3: ready=1, start pulse at 500 accepts, rst at 1000 accepts.
  task automatic run_stream(input int mode, output int first_oe, output int first_vld);
    exp_t        e;
    logic [31:0] run_sum;
    int          cyc, acc, issued, exp_addr, hold, hcyc;
    bit          pulsed, stopped;
    cyc = 0; acc = 0; issued = 0; exp_addr = 0; hold = 0; hcyc = 0;
    pulsed = 0; stopped = 0; run_sum = 32'd0;
    first_oe = -1; first_vld = -1;
    while (exp_q.size() > 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      case (mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (hold > 0) begin
            out_ready = 1'b0;
            hold--;
            hcyc++;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
      if (mode == 3 && acc == 500 && !pulsed) begin
        start  = 1'b1;
        pulsed = 1;
      end

      if (oe) begin
        total++;
        if (exp_addr >= 4096 || a !== 20'(exp_addr)) begin
          bad++;
          $display("FAIL ram_addr: got %0d want %0d (reads so far %0d)", a, exp_addr, exp_addr);
        end
        if (first_oe < 0) first_oe = cyc;
        exp_addr++;
        issued++;
      end else if (mode == 0 && first_oe >= 0 && exp_addr < 4096) begin
        total++; bad++;
        $display("FAIL oe_gap: RAM2_OE=0 at cycle %0d want 1 (next addr %0d)", cyc, exp_addr);
      end

      if (mode == 2 && hcyc >= 2 && hold < 9 && out_ready == 1'b0) begin
        total++;
        if (oe !== 1'b0) begin
          bad++;
          $display("FAIL oe_stall: RAM2_OE=%b during backpressure want 0", oe);
        end
      end

      total++;
      if (issued - acc > 2) begin
        bad++;
        $display("FAIL occupancy: outstanding=%0d want <=2", issued - acc);
      end

      total++;
      if (cs !== run_sum) begin
        bad++;
        $display("FAIL live_checksum: got %0h want %0h", cs, run_sum);
      end

      total++;
      if (!v && l) begin
        bad++;
        $display("FAIL last_idle: out_last=1 with out_valid=0 want 0");
      end

      if (v && first_vld < 0) first_vld = cyc;
      if (mode == 0 && first_vld >= 0 && !v) begin
        total++; bad++;
        $display("FAIL valid_gap: out_valid=0 at cycle %0d want 1", cyc);
      end

      if (v && out_ready) begin
        e = exp_q.pop_front();
        total++;
        if (d !== e.data || l !== e.last) begin
          bad++;
          $display("FAIL stream_word %0d: got %0h/last=%b want %0h/last=%b", acc, d, l, e.data, e.last);
        end
        run_sum = run_sum + 32'(d);
        acc++;
        if (mode == 2 && acc == 101) begin
          hold = 10;
          hcyc = 0;
        end
        if (mode == 3 && acc == 1000) begin
          rst     = 1'b1;
          stopped = 1;
          break;
        end
      end
    end
    if (!stopped) begin
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL stream_timeout: %0d words missing want 0", exp_q.size());
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; start1 = 1'b0; ready1 = 1'b1; m1 = 24'h0;
    repeat (3) @(negedge clk);
    total++;
    if ({oe, v, l, busy, fin} !== 5'b0 || a !== 20'd0 || d !== 24'd0 || cs !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: oe=%b v=%b l=%b busy=%b fin=%b a=%0h d=%0h cs=%0h want all 0",
               oe, v, l, busy, fin, a, d, cs);
    end
    total++;
    if ({oe1, v1, busy1, fin1} !== 4'b0 || cs1 !== 32'd0) begin
      bad++;
      $display("FAIL reset_state1: oe=%b v=%b busy=%b fin=%b cs=%0h want all 0", oe1, v1, busy1, fin1, cs1);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_rate();
    int fo, fv;
    load_pass(0);
    run_stream(0, fo, fv);
    total++;
    if (fo !== 2 || fv !== 3) begin
      bad++;
      $display("FAIL latency: first_oe=%0d first_valid=%0d want 2 and 3", fo, fv);
    end
    @(negedge clk);
    total++;
    if (fin !== 1'b0 || v !== 1'b0) begin
      bad++;
      $display("FAIL full_drain: finished=%b valid=%b want 0 0", fin, v);
    end
    @(negedge clk);
    total++;
    if (fin !== 1'b1 || busy !== 1'b0 || cs !== 32'h007FF800) begin
      bad++;
      $display("FAIL full_done: fin=%b busy=%b cs=%0h want 1 0 7ff800", fin, busy, cs);
    end
  endtask

  task automatic test_backpressure();
    int fo, fv;
    load_pass(0);
    run_stream(2, fo, fv);
    repeat (2) @(negedge clk);
    total++;
    if (fin !== 1'b1 || cs !== 32'h007FF800) begin
      bad++;
      $display("FAIL bp_done: fin=%b cs=%0h want 1 7ff800", fin, cs);
    end
  endtask

  task automatic test_random_ready();
    int fo, fv;
    load_pass(1);
    run_stream(1, fo, fv);
    repeat (2) @(negedge clk);
    total++;
    if (fin !== 1'b1 || cs !== exp_sum) begin
      bad++;
      $display("FAIL rand_done: fin=%b cs=%0h want 1 %0h", fin, cs, exp_sum);
    end
  endtask

  task automatic test_wrap();
    int fo, fv;
    load_pass(2);
    run_stream(0, fo, fv);
    repeat (2) @(negedge clk);
    total++;
    if (fin !== 1'b1 || cs !== 32'hFFFFF000) begin
      bad++;
      $display("FAIL wrap_checksum: fin=%b cs=%0h want 1 fffff000", fin, cs);
    end
  endtask

  task automatic test_reset_mid();
    int fo, fv;
    load_pass(0);
    run_stream(3, fo, fv);
    @(negedge clk);
    total++;
    if ({oe, v, l, busy, fin} !== 5'b0 || a !== 20'd0 || d !== 24'd0 || cs !== 32'd0) begin
      bad++;
      $display("FAIL mid_reset: oe=%b v=%b l=%b busy=%b fin=%b a=%0h d=%0h cs=%0h want all 0",
               oe, v, l, busy, fin, a, d, cs);
    end
    rst = 1'b0;
    load_pass(0);
    run_stream(0, fo, fv);
    total++;
    if (fo !== 2 || fv !== 3) begin
      bad++;
      $display("FAIL restart_latency: first_oe=%0d first_valid=%0d want 2 and 3", fo, fv);
    end
    repeat (2) @(negedge clk);
    total++;
    if (fin !== 1'b1 || cs !== 32'h007FF800) begin
      bad++;
      $display("FAIL restart_done: fin=%b cs=%0h want 1 7ff800", fin, cs);
    end
  endtask

  task automatic test_single();
    int oe_n, got;
    m1 = 24'h123456;
    ready1 = 1'b1;
    for (int p = 0; p < 2; p++) begin
      oe_n = 0; got = 0;
      @(negedge clk);
      start1 = 1'b1;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        start1 = 1'b0;
        if (oe1) begin
          oe_n++;
          total++;
          if (a1 !== 20'd0) begin
            bad++;
            $display("FAIL single_addr pass %0d: got %0h want 0", p, a1);
          end
        end
        if (v1 && ready1) begin
          got++;
          total++;
          if (d1 !== 24'h123456 || l1 !== 1'b1) begin
            bad++;
            $display("FAIL single_word pass %0d: got %0h/last=%b want 123456/last=1", p, d1, l1);
          end
        end
      end
      total++;
      if (oe_n !== 1 || got !== 1) begin
        bad++;
        $display("FAIL single_counts pass %0d: oe pulses=%0d words=%0d want 1 1", p, oe_n, got);
      end
      total++;
      if (cs1 !== 32'h00123456 || fin1 !== 1'b1 || busy1 !== 1'b0) begin
        bad++;
        $display("FAIL single_done pass %0d: cs=%0h fin=%b busy=%b want 123456 1 0", p, cs1, fin1, busy1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_backpressure();
    test_random_ready();
    test_wrap();
    test_reset_mid();
    test_single();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
